// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between instruction fetch (IF)
// and the data-memory stage (MEM). One request is served at a time and is
// split into back-to-back byte accesses. Read bytes are assembled
// little-endian (with optional sign extension for MEM loads), and every
// request finishes with a single-cycle done pulse on the granted port.
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_done,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_len,
  input  logic              d_sext,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_dout,
  output logic              ram_wr,
  input  logic [7:0]        ram_din,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } state_t;

  // Read latency in the widths used by the byte-capture bookkeeping.
  localparam logic [2:0] LAT3 = 3'(RD_LAT);
  localparam logic [1:0] LAT2 = 2'(RD_LAT);

  state_t            state;

  // Latched copy of the granted request.
  logic [ADDR_W-1:0] base_addr;
  logic [1:0]        last_idx;   // transfer length minus one (0, 1 or 3)
  logic              sext_q;
  logic              port_d;     // 1 = MEM owns the transfer, 0 = IF
  logic [31:0]       wdata_q;

  // Edges elapsed since the grant edge, and the read assembly buffer.
  logic [2:0]        cyc;
  logic [31:0]       rbuf;

  // Grant candidate selected from the requesters.
  logic              g_valid;
  logic              g_port_d;
  logic [ADDR_W-1:0] g_addr;
  logic              g_we;
  logic              g_sext;
  logic [31:0]       g_wdata;
  logic [1:0]        g_last;

  // Per-cycle transfer bookkeeping.
  logic              issue_now;
  logic              cap_now;
  logic [1:0]        cap_idx;
  logic              last_cap;
  logic              wr_last;
  logic [31:0]       merged;

  // Picks byte k of a little-endian word.
  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] k);
    logic [7:0] b;
    case (k)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

  // Applies byte/half/word load formatting; IF always passes len 3, sext 0.
  function automatic logic [31:0] format_load(input logic [31:0] raw,
                                              input logic [1:0]  li,
                                              input logic        sx);
    logic [31:0] r;
    case (li)
      2'd0:    r = {{24{sx & raw[7]}}, raw[7:0]};
      2'd1:    r = {{16{sx & raw[15]}}, raw[15:0]};
      default: r = raw;
    endcase
    return r;
  endfunction

  assign busy = (state != IDLE);

  // MEM wins over IF whenever both request in IDLE.
  always_comb begin
    g_valid  = d_req | if_req;
    g_port_d = d_req;
    g_addr   = if_addr;
    g_we     = 1'b0;
    g_sext   = 1'b0;
    g_wdata  = '0;
    g_last   = 2'd3;
    if (d_req) begin
      g_addr  = d_addr;
      g_we    = d_we;
      g_sext  = d_sext;
      g_wdata = d_wdata;
      g_last  = d_len[1] ? 2'd3 : {1'b0, d_len[0]};
    end
  end

  // Decides which byte is issued / captured at the coming edge.
  always_comb begin
    issue_now = (cyc <= {1'b0, last_idx});
    cap_now   = (cyc >= LAT3);
    cap_idx   = cyc[1:0] - LAT2;
    last_cap  = (cyc == ({1'b0, last_idx} + LAT3));
    wr_last   = (cyc == ({1'b0, last_idx} + 3'd1));
  end

  // Read buffer with the byte arriving this cycle dropped into its lane.
  always_comb begin
    merged = rbuf;
    case (cap_idx)
      2'd0:    merged[7:0]   = ram_din;
      2'd1:    merged[15:8]  = ram_din;
      2'd2:    merged[23:16] = ram_din;
      default: merged[31:24] = ram_din;
    endcase
  end

  // Arbitration/transfer FSM driving every registered output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      base_addr <= '0;
      last_idx  <= 2'd0;
      sext_q    <= 1'b0;
      port_d    <= 1'b0;
      wdata_q   <= '0;
      cyc       <= 3'd0;
      rbuf      <= '0;
      ram_addr  <= '0;
      ram_dout  <= 8'h00;
      ram_wr    <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      if_done   <= 1'b0;
      d_done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (g_valid) begin
            base_addr <= g_addr;
            last_idx  <= g_last;
            sext_q    <= g_sext;
            port_d    <= g_port_d;
            wdata_q   <= g_wdata;
            cyc       <= 3'd1;
            rbuf      <= '0;
            ram_addr  <= g_addr;
            ram_wr    <= g_we;
            ram_dout  <= g_we ? g_wdata[7:0] : 8'h00;
            state     <= g_we ? WR : RD;
          end
        end

        WR: begin
          if (wr_last) begin
            ram_wr   <= 1'b0;
            ram_addr <= '0;
            ram_dout <= 8'h00;
            state    <= DONE;
            if (port_d) begin
              d_done <= 1'b1;
            end else begin
              if_done <= 1'b1;
            end
          end else begin
            ram_addr <= base_addr + ADDR_W'(cyc);
            ram_dout <= byte_of(wdata_q, cyc[1:0]);
            cyc      <= cyc + 3'd1;
          end
        end

        RD: begin
          if (cap_now) begin
            rbuf <= merged;
          end
          if (last_cap) begin
            ram_addr <= '0;
            state    <= DONE;
            if (port_d) begin
              d_rdata <= format_load(merged, last_idx, sext_q);
              d_done  <= 1'b1;
            end else begin
              if_rdata <= merged;
              if_done  <= 1'b1;
            end
          end else begin
            if (issue_now) begin
              ram_addr <= base_addr + ADDR_W'(cyc);
            end
            cyc <= cyc + 3'd1;
          end
        end

        DONE: begin
          if_done <= 1'b0;
          d_done  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
